// File: rtl/mem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: the bus word, the FSM state encoding
// and a small address helper.
package mem_arbiter_pkg;

  typedef logic [31:0] word;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_RD_WAIT,
    ARB_RD_GAP,
    ARB_WR
  } arb_state_t;

  localparam int CNT_W = 8;

  // Address 0 on the read port means "no read", so a read of 0 never touches memory.
  function automatic logic isNoRead(input word addr);
    return (addr == '0);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester handshake and memory port bundle.
// The slave view is the arbiter; the master view is the core and memory around it.
interface mem_arbiter_if import mem_arbiter_pkg::*; #(parameter int N_REQ = 2);

  logic [N_REQ-1:0] i_req_valid;
  logic [N_REQ-1:0] i_req_we;
  word              i_req_addr  [N_REQ];
  word              i_req_wdata [N_REQ];
  logic [N_REQ-1:0] o_req_ready;
  logic [N_REQ-1:0] o_resp_valid;
  word              o_resp_rdata;
  word              o_r_mem_addr;
  word              i_r_mem_data;
  word              o_w_mem_addr [0:1];
  word              o_w_mem_data [0:1];
  logic [0:1]       o_w_mem_en;

  modport slave (
    input  i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_r_mem_data,
    output o_req_ready, o_resp_valid, o_resp_rdata, o_r_mem_addr,
           o_w_mem_addr, o_w_mem_data, o_w_mem_en
  );

  modport master (
    output i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_r_mem_data,
    input  o_req_ready, o_resp_valid, o_resp_rdata, o_r_mem_addr,
           o_w_mem_addr, o_w_mem_data, o_w_mem_en
  );

endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// Round-robin picker: first valid requester at or after ptr_i, wrapping modulo N_REQ.
// Purely combinational; the pointer register lives in the arbiter.
module rr_picker #(
  parameter  int N_REQ = 2,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset back to ptr so the nearest valid requester wins last.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = '0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      cand = IDX_W'((int'(ptr_i) + off) % N_REQ);
      if (valid_i[cand]) begin
        idx_o = cand;
        any_o = 1'b1;
      end
    end
    if (any_o) grant_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one byte-addressed data memory between N_REQ requesters with round-robin
// grant, one word read or write per access, and a one-cycle response pulse.
module mem_arbiter import mem_arbiter_pkg::*; #(
  parameter int N_REQ      = 2,
  parameter int MEM_RD_LAT = 1,
  parameter int MEM_GAP    = 1
) (
  input logic           i_clk,
  input logic           i_rst,
  mem_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(N_REQ);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] rrPtr_q, rrPtr_d;
  logic [IDX_W-1:0] gnt_q, gnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] respValid_q, respValid_d;
  word              rdata_q, rdata_d;
  word              rdAddr_q, rdAddr_d;
  word              wrAddr_q, wrAddr_d;
  word              wrData_q, wrData_d;
  logic             wrEn_q, wrEn_d;
  logic [N_REQ-1:0] ready;
  logic [N_REQ-1:0] pickGrant;
  logic [IDX_W-1:0] pickIdx;
  logic             pickAny;

  rr_picker #(.N_REQ(N_REQ)) u_picker (
    .valid_i (bus.i_req_valid),
    .ptr_i   (rrPtr_q),
    .grant_o (pickGrant),
    .idx_o   (pickIdx),
    .any_o   (pickAny)
  );

  // Memory-side outputs default to 0 each cycle so every drive lasts exactly one cycle.
  always_comb begin
    state_d     = state_q;
    rrPtr_d     = rrPtr_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    respValid_d = '0;
    rdata_d     = rdata_q;
    rdAddr_d    = '0;
    wrAddr_d    = '0;
    wrData_d    = '0;
    wrEn_d      = 1'b0;
    ready       = '0;
    unique case (state_q)
      ARB_IDLE: begin
        if (pickAny && !i_rst) begin
          ready   = pickGrant;
          gnt_d   = pickIdx;
          rrPtr_d = IDX_W'((int'(pickIdx) + 1) % N_REQ);
          cnt_d   = '0;
          if (bus.i_req_we[pickIdx]) begin
            wrEn_d   = 1'b1;
            wrAddr_d = bus.i_req_addr[pickIdx];
            wrData_d = bus.i_req_wdata[pickIdx];
            state_d  = ARB_WR;
          end else if (isNoRead(bus.i_req_addr[pickIdx])) begin
            respValid_d = pickGrant;
            rdata_d     = '0;
            state_d     = ARB_RD_GAP;
          end else begin
            rdAddr_d = bus.i_req_addr[pickIdx];
            state_d  = ARB_RD_WAIT;
          end
        end
      end
      ARB_RD_WAIT: begin
        if (cnt_q == CNT_W'(MEM_RD_LAT)) begin
          rdata_d              = bus.i_r_mem_data;
          respValid_d[gnt_q]   = 1'b1;
          cnt_d                = '0;
          state_d              = ARB_RD_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ARB_RD_GAP: begin
        if (int'(cnt_q) + 1 >= MEM_GAP) state_d = ARB_IDLE;
        else                            cnt_d   = cnt_q + 1'b1;
      end
      ARB_WR: begin
        respValid_d[gnt_q] = 1'b1;
        rdata_d            = '0;
        state_d            = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Reset aborts any access in flight: pending responses and write enables vanish.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ARB_IDLE;
      rrPtr_q     <= '0;
      gnt_q       <= '0;
      cnt_q       <= '0;
      respValid_q <= '0;
      rdata_q     <= '0;
      rdAddr_q    <= '0;
      wrAddr_q    <= '0;
      wrData_q    <= '0;
      wrEn_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rrPtr_q     <= rrPtr_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      respValid_q <= respValid_d;
      rdata_q     <= rdata_d;
      rdAddr_q    <= rdAddr_d;
      wrAddr_q    <= wrAddr_d;
      wrData_q    <= wrData_d;
      wrEn_q      <= wrEn_d;
    end
  end

  assign bus.o_req_ready     = ready;
  assign bus.o_resp_valid    = respValid_q;
  assign bus.o_resp_rdata    = rdata_q;
  assign bus.o_r_mem_addr    = rdAddr_q;
  assign bus.o_w_mem_addr[0] = wrAddr_q;
  assign bus.o_w_mem_addr[1] = '0;
  assign bus.o_w_mem_data[0] = wrData_q;
  assign bus.o_w_mem_data[1] = '0;
  assign bus.o_w_mem_en      = {wrEn_q, 1'b0};

endmodule
